mul_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one multi-cycle shift-add/radix-4 multiplier core among NUM_REQ requesters.
- Accepts operand requests, issues one load pulse to the core and waits for its done strobe.
- Returns the product tagged with the requester ID over a valid/ready response port.
- Sits between the datapath clients and the multiplier core; only one operation is in flight at a time.

---
 rtl/mul_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_mul_share_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one multi-cycle multiplier core among NUM_REQ clients.
// Define MUL_ARB_TIMEOUT_EN to build a watchdog that aborts WAIT after TIMEOUT cycles.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_sign,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       mul_load,
  output logic                       mul_sign,
  output logic [WIDTH-1:0]           mul_multiplicand,
  output logic [WIDTH-1:0]           mul_multiplier,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Handshakes: req_* transfers when req_valid[i] && req_ready[i] (IDLE only);
  // rsp_* transfers when rsp_valid && rsp_ready, and rsp_* holds steady until then.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_found;
  logic [ID_W-1:0]    cap_id;
  logic               cap_sign;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic [2*WIDTH-1:0] data_q;
  logic               timeout_hit;
  int                 cand;

  // Search starts just past the last winner so every active client is served once per round.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          state_next          = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mul_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      cap_id   <= '0;
      cap_sign <= 1'b0;
      cap_a    <= '0;
      cap_b    <= '0;
      data_q   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_found) begin
        rr_ptr   <= grant_id;
        cap_id   <= grant_id;
        cap_sign <= req_sign[grant_id];
        cap_a    <= req_a[grant_id*WIDTH +: WIDTH];
        cap_b    <= req_b[grant_id*WIDTH +: WIDTH];
      end
      // A watchdog abort reports a zero product rather than stale data.
      if (state == WAIT && (mul_done || timeout_hit)) begin
        data_q <= mul_done ? mul_result : '0;
      end
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT) && !mul_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (mul_done) err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;

  // TIMEOUT has no effect without the watchdog; referenced here only to keep it bound.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign mul_load         = (state == ISSUE);
  assign mul_sign         = cap_sign;
  assign mul_multiplicand = cap_a;
  assign mul_multiplier   = cap_b;
  assign rsp_valid        = (state == RESP);
  assign rsp_id           = cap_id;
  assign rsp_data         = data_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter; the bench itself plays the multiplier core.
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_sign;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     mul_load;
  logic                     mul_sign;
  logic [WIDTH-1:0]         mul_multiplicand;
  logic [WIDTH-1:0]         mul_multiplier;
  logic                     mul_done;
  logic [2*WIDTH-1:0]       mul_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [2*WIDTH-1:0]       rsp_data;
  logic                     rsp_err;
  logic                     busy;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
    .req_a(req_a), .req_b(req_b),
    .mul_load(mul_load), .mul_sign(mul_sign),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_done(mul_done), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Clock / reset-independent timing: inputs change on negedge, outputs sampled 1 ns later.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Caller has already driven req_valid at a negedge of an IDLE cycle.
  task automatic do_op(input int id, input logic [31:0] ea, input logic [31:0] eb,
                       input logic es, input int lat, input logic [63:0] res,
                       input int stall, input bit clear);
    logic [NUM_REQ-1:0] onehot;
    onehot = 4'b0001 << id;
    #1;
    chk("grant", 64'(req_ready), 64'(onehot));
    @(negedge clk);
    if (clear) req_valid = '0;
    #1;
    chk("load_pulse", 64'(mul_load), 64'd1);
    chk("op_a", 64'(mul_multiplicand), 64'(ea));
    chk("op_b", 64'(mul_multiplier), 64'(eb));
    chk("op_sign", 64'(mul_sign), 64'(es));
    chk("ready_in_issue", 64'(req_ready), 64'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) chk("load_once", 64'(mul_load), 64'd0);
    end
    @(negedge clk);
    mul_done   = 1'b1;
    mul_result = res;
    #1;
    chk("sign_held", 64'(mul_sign), 64'(es));
    chk("op_a_held", 64'(mul_multiplicand), 64'(ea));
    chk("no_rsp_in_wait", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    mul_done   = 1'b0;
    mul_result = '0;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(id));
    chk("rsp_data", rsp_data, res);
    chk("rsp_err", 64'(rsp_err), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_id", 64'(rsp_id), 64'(id));
      chk("stall_data", rsp_data, res);
      chk("stall_no_grant", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("idle_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_sign   = '0;
    req_a      = '0;
    req_b      = '0;
    mul_done   = 1'b0;
    mul_result = '0;
    rsp_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_load", 64'(mul_load), 64'd0);
    chk("rst_op_a", 64'(mul_multiplicand), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with every requester active: expected order 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 32'(10 + i);
      req_b[i*WIDTH +: WIDTH] = 32'(20 + i);
    end
    @(negedge clk);
    req_valid = 4'b1111;
    do_op(0, 32'd10, 32'd20, 1'b0, 3, 64'd200, 0, 1'b0);
    do_op(1, 32'd11, 32'd21, 1'b0, 3, 64'd231, 0, 1'b0);
    do_op(2, 32'd12, 32'd22, 1'b0, 3, 64'd264, 0, 1'b0);
    do_op(3, 32'd13, 32'd23, 1'b0, 3, 64'd299, 0, 1'b0);
    do_op(0, 32'd10, 32'd20, 1'b0, 3, 64'd200, 0, 1'b1);

    // Single request, 7*6 with a 17-cycle core
    req_a[31:0] = 32'd7;
    req_b[31:0] = 32'd6;
    req_valid   = 4'b0001;
    do_op(0, 32'd7, 32'd6, 1'b0, 17, 64'd42, 0, 1'b1);

    // Backpressure on requester 1 while requester 3 keeps asking
    req_valid = 4'b1010;
    do_op(1, 32'd11, 32'd21, 1'b0, 2, 64'd231, 10, 1'b0);
    do_op(3, 32'd13, 32'd23, 1'b0, 2, 64'd299, 0, 1'b1);

    // Signed pass-through on requester 2
    req_sign[2]   = 1'b1;
    req_a[64 +: 32] = 32'hFFFF_FFFD;
    req_b[64 +: 32] = 32'd5;
    req_valid     = 4'b0100;
    do_op(2, 32'hFFFF_FFFD, 32'd5, 1'b1, 5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b1);
    req_sign[2] = 1'b0;

    // A done strobe while idle must not produce a response
    @(negedge clk);
    mul_done   = 1'b1;
    mul_result = 64'd77;
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    chk("idle_done_ignored", 64'(rsp_valid), 64'd0);
    chk("idle_done_busy", 64'(busy), 64'd0);

    // Reset while waiting on the core
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_load", 64'(mul_load), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mul_done   = 1'b1;
    mul_result = 64'd55;
    @(negedge clk);
    mul_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
      chk("post_reset_no_load", 64'(mul_load), 64'd0);
      @(negedge clk);
    end

    // After reset requester 0 has first priority again
    req_valid = 4'b1001;
    do_op(0, 32'd7, 32'd6, 1'b0, 2, 64'd42, 0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
